uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised UART transmitter that follows the single-byte, unbuffered UART TX. It adds:
- Configurable data width and oversample ratio.
- An internal transmit FIFO, so software can queue words back-to-back.
- Working CTS flow control.
- A programmable inter-character guard time.

It sits between the IO_SIF host-side register/command logic and the LVDS board-level UART pin. It shares the baud-tick generator with the RX path.

Parameters:
P_DATA_W, 8, data bits per frame (legal 5..9), sent LSB first
P_OVS, 16, baud ticks per UART bit (legal 4..64)
P_FIFO_AW, 4, FIFO address width; depth = 2**P_FIFO_AW words

Ports:
FPGA_CLK  in  1  system clock; sole clock of the block
FPGA_RST_N  in  1  reset; one clock; reset is synchronous and active-low
IBAUD_TICK  in  1  one-cycle pulse at P_OVS x baud rate
ITX_DVLD  in  1  host write strobe
ITX_DT  in  P_DATA_W  host write data
OTX_READY  out  1  FIFO not full; a write is accepted when ITX_DVLD and OTX_READY are both 1
OTX_OVF  out  1  one-cycle pulse when ITX_DVLD=1 while OTX_READY=0 (word dropped)
OFIFO_LVL  out  P_FIFO_AW+1  number of words queued
OTX_BUSY  out  1  FSM not in IDLE
OTX_DONE  out  1  one-cycle pulse on the last cycle of each frame (end of guard, or end of stop if guard=0)
OTXD  out  1  serial output, registered
ICTS  in  1  clear-to-send, active low, asynchronous to FPGA_CLK
ICTS_EN  in  1  1 = honour ICTS
IPARITY_EN  in  1  1 = append parity bit
IODD_PARITY  in  1  1 = odd parity, 0 = even
ISTOP2_EN  in  1  1 = two stop bits
IGUARD  in  2  idle-high bit times inserted after stop (0..3)

Behaviour:
- Reset (FPGA_RST_N=0 at a rising edge):
  - FIFO emptied, FSM to IDLE, counters cleared.
  - Outputs: OTXD=1, OTX_READY=1, OFIFO_LVL=0, OTX_BUSY=0, OTX_DONE=0, OTX_OVF=0.
  - Reset mid-frame aborts immediately; OTXD returns to 1 on that edge and no partial frame is resumed.
- ICTS is passed through a 2-flop synchroniser (reset value 1) before use.
- FIFO:
  - Write when ITX_DVLD and not full.
  - Read (pop) is issued by the FSM only.
  - Simultaneous write and pop: the level is unchanged.
  - Write while full: rejected and OTX_OVF pulses, even if a pop occurs in the same cycle.
  - Pointers wrap modulo depth; full/empty are derived from the level counter.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, GUARD.
  - IDLE -> START when the FIFO is not empty and (ICTS_EN=0 or synchronised ICTS=0).
    - On this edge: pop the FIFO, latch the word into the shift register, and latch IPARITY_EN/IODD_PARITY/ISTOP2_EN/IGUARD.
    - Compute parity over P_DATA_W bits: even = XOR-reduce, odd = inverted XOR-reduce.
  - Bit timing:
    - A bit counter (0..P_OVS-1) clears on every state entry and increments on IBAUD_TICK.
    - bit_end = IBAUD_TICK and counter = P_OVS-1, so every bit lasts exactly P_OVS ticks.
  - START -> DATA on bit_end.
  - DATA: shift right on bit_end. After P_DATA_W bits, go to PARITY if the latched parity enable is set, else STOP1.
  - PARITY -> STOP1 on bit_end.
  - STOP1 -> STOP2 if the latched stop2 is set, else GUARD if the latched guard count is non-zero, else IDLE.
  - STOP2 -> GUARD or IDLE by the same guard rule.
  - GUARD holds for (latched guard) bit times, then goes to IDLE.
- OTXD is registered from the next state and data, so it changes on the same edge as the state.
  - START=0; DATA = current LSB; PARITY = latched parity; all other states = 1.
- Latency: a write accepted at edge k into an empty FIFO with CTS clear gives START and OTXD=0 from edge k+1.
- CTS is sampled only in IDLE. Deassertion mid-frame does not abort; the current frame completes and the next frame waits.
- Config inputs changed mid-frame affect only the next frame.
- Back-to-back frames: the IDLE cycle between frames lasts one clock only; OTX_DONE pulses during the final state's last cycle.
- Default states decode to IDLE.

Decomposition:
- Package uart_tx_pkg holds:
  - The state enumeration (3-bit).
  - Width helper constants: bit-counter width = clog2(P_OVS), data-counter width = clog2(P_DATA_W+1).
  - Parity function.
- Sub-module uart_tx_fifo: synchronous single-clock FIFO parametrised by width and address width. Outputs level, full and empty; registered read data valid the cycle after pop is not required (show-ahead read).

Test Plan:
1. Reset, then P_DATA_W=8, P_OVS=16, IBAUD_TICK every cycle, no parity, 1 stop, guard 0. Write 0x55 -> OTXD shows 0,1,0,1,0,1,0,1,0,1, each held 16 cycles; OTX_DONE at cycle 160 after START; OTX_BUSY low afterwards.
2. Parity. Even parity, write 0x07 -> parity bit = 1. Odd parity, write 0x07 -> parity bit = 0. With ISTOP2_EN=1 and IGUARD=2, the frame is 1+8+1+2+2 = 14 bit times = 224 cycles.
3. FIFO fill.
   - ICTS_EN=1, ICTS=1, write 16 words -> OFIFO_LVL=16, OTX_READY=0, OTXD stays 1.
   - 17th write -> OTX_OVF pulse, level stays 16.
   - ICTS=0 -> 16 frames sent back-to-back, in order, with a one-clock IDLE between frames.
4. CTS mid-frame: raise ICTS during DATA -> the frame completes, the next queued frame does not start until ICTS=0 has passed the 2-cycle synchroniser plus one edge.
5. Reset mid-frame: FPGA_RST_N=0 for one edge during DATA with 3 words queued -> OTXD=1 on that edge, OFIFO_LVL=0, no further frames.
6. P_DATA_W=5, P_OVS=4, IBAUD_TICK every 3rd cycle. Write 0x1F with IPARITY_EN=1 and odd parity -> 8 bits x 12 cycles; parity bit = 0; the upper ITX_DT bits are ignored.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_tx_pkg;

  // Transmit FSM states; encoding 3'd7 is unused and decodes to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_GUARD  = 3'd6
  } tx_state_e;

  // Widest legal data word.
  localparam int MAX_DATA_W = 9;

  // Width of the per-bit oversample counter (0..ovs-1).
  function automatic int bit_cnt_w(input int ovs);
    return $clog2(ovs);
  endfunction

  // Width of the data-bit / guard-bit index counter.
  function automatic int data_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

  // Parity over the low 'width' bits: even = XOR-reduce, odd = its inverse.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input int width,
                                       input logic odd);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) begin
        p = p ^ data[i];
      end
    end
    return p ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock show-ahead FIFO; full/empty come from the level counter.
module uart_tx_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == (AW+1)'(0));
  assign wr_ok   = wr & ~full;
  assign rd_ok   = rd & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the depth; level tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with TX FIFO, CTS flow control and guard time.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int P_DATA_W  = 8,
  parameter int P_OVS     = 16,
  parameter int P_FIFO_AW = 4
) (
  input  logic                 FPGA_CLK,
  input  logic                 FPGA_RST_N,
  input  logic                 IBAUD_TICK,
  input  logic                 ITX_DVLD,
  input  logic [P_DATA_W-1:0]  ITX_DT,
  output logic                 OTX_READY,
  output logic                 OTX_OVF,
  output logic [P_FIFO_AW:0]   OFIFO_LVL,
  output logic                 OTX_BUSY,
  output logic                 OTX_DONE,
  output logic                 OTXD,
  input  logic                 ICTS,
  input  logic                 ICTS_EN,
  input  logic                 IPARITY_EN,
  input  logic                 IODD_PARITY,
  input  logic                 ISTOP2_EN,
  input  logic [1:0]           IGUARD
);
  localparam int BCW = bit_cnt_w(P_OVS);
  localparam int DCW = data_cnt_w(P_DATA_W);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(P_OVS - 1);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(P_DATA_W - 1);

  tx_state_e            state;
  tx_state_e            state_nx;
  logic                 cts_meta;
  logic                 cts_sync;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [P_DATA_W-1:0]  fifo_data;
  logic                 pop;
  logic [BCW-1:0]       bit_cnt;
  logic [DCW-1:0]       idx;
  logic [P_DATA_W-1:0]  shreg;
  logic [P_DATA_W-1:0]  shreg_nx;
  logic                 par_en;
  logic                 par_bit;
  logic                 stop2;
  logic [1:0]           guard;
  logic                 txd;
  logic                 txd_nx;
  logic                 bit_end;
  logic                 done;
  logic                 cts_ok;

  uart_tx_fifo #(
    .W  (P_DATA_W),
    .AW (P_FIFO_AW)
  ) u_fifo (
    .clk     (FPGA_CLK),
    .rst_n   (FPGA_RST_N),
    .wr      (ITX_DVLD),
    .wr_data (ITX_DT),
    .rd      (pop),
    .rd_data (fifo_data),
    .level   (OFIFO_LVL),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_end   = IBAUD_TICK & (bit_cnt == BIT_LAST);
  assign cts_ok    = ~ICTS_EN | ~cts_sync;
  assign OTX_READY = ~fifo_full;
  assign OTX_OVF   = ITX_DVLD & fifo_full;
  assign OTX_BUSY  = (state != ST_IDLE);
  assign OTX_DONE  = done;
  assign OTXD      = txd;

  // Two-flop synchroniser for the asynchronous clear-to-send input.
  always_ff @(posedge FPGA_CLK) begin
    if (!FPGA_RST_N) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= ICTS;
      cts_sync <= cts_meta;
    end
  end

  // Next-state, FIFO pop, shift and end-of-frame decode.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    pop      = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && cts_ok) begin
          state_nx = ST_START;
          pop      = 1'b1;
          shreg_nx = fifo_data;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) state_nx = ST_DATA;
        else         state_nx = ST_START;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_nx = shreg >> 1;
          if (idx == DATA_LAST) state_nx = par_en ? ST_PARITY : ST_STOP1;
          else                  state_nx = ST_DATA;
        end else begin
          state_nx = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end) state_nx = ST_STOP1;
        else         state_nx = ST_PARITY;
      end
      ST_STOP1: begin
        if (bit_end) begin
          if (stop2) begin
            state_nx = ST_STOP2;
          end else if (guard != 2'd0) begin
            state_nx = ST_GUARD;
          end else begin
            state_nx = ST_IDLE;
            done     = 1'b1;
          end
        end else begin
          state_nx = ST_STOP1;
        end
      end
      ST_STOP2: begin
        if (bit_end) begin
          if (guard != 2'd0) begin
            state_nx = ST_GUARD;
          end else begin
            state_nx = ST_IDLE;
            done     = 1'b1;
          end
        end else begin
          state_nx = ST_STOP2;
        end
      end
      ST_GUARD: begin
        if (bit_end && ((idx + DCW'(1)) == DCW'(guard))) begin
          state_nx = ST_IDLE;
          done     = 1'b1;
        end else begin
          state_nx = ST_GUARD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Serial line value for the state being entered, so OTXD moves with the state.
  always_comb begin
    txd_nx = 1'b1;
    case (state_nx)
      ST_START:  txd_nx = 1'b0;
      ST_DATA:   txd_nx = shreg_nx[0];
      ST_PARITY: txd_nx = par_bit;
      default:   txd_nx = 1'b1;
    endcase
  end

  // State, shift register, line register and bit/index counters.
  always_ff @(posedge FPGA_CLK) begin
    if (!FPGA_RST_N) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      txd     <= 1'b1;
      bit_cnt <= '0;
      idx     <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      txd   <= txd_nx;
      if (state_nx != state) begin
        bit_cnt <= '0;
        idx     <= '0;
      end else if (bit_end) begin
        bit_cnt <= '0;
        idx     <= idx + DCW'(1);
      end else if (IBAUD_TICK && (state != ST_IDLE)) begin
        bit_cnt <= bit_cnt + BCW'(1);
      end else begin
        bit_cnt <= bit_cnt;
      end
    end
  end

  // Frame configuration and parity captured when a word is popped.
  always_ff @(posedge FPGA_CLK) begin
    if (!FPGA_RST_N) begin
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2   <= 1'b0;
      guard   <= 2'd0;
    end else if (pop) begin
      par_en  <= IPARITY_EN;
      par_bit <= calc_parity(MAX_DATA_W'(fifo_data), P_DATA_W, IODD_PARITY);
      stop2   <= ISTOP2_EN;
      guard   <= IGUARD;
    end
  end

endmodule
